// File: rtl/mux4to1_pkg.sv
// Shared select-code definitions for the 4:1 selector leaf cell.
package mux4to1_pkg;

  // Select code as seen on the sel port.
  typedef logic [1:0] sel_t;

  // One-hot select lines: bit 0 = a, bit 1 = b, bit 2 = c, bit 3 = d.
  typedef logic [3:0] onehot_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux4to1_if.sv
// Data/select bundle for the 4:1 selector: the driver owns the inputs,
// the selector owns the combinational and registered outputs.
interface mux4to1_if #(
  parameter int WIDTH = 1
);
  import mux4to1_pkg::*;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  sel_t             sel;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;

  modport master (
    output a, b, c, d, sel,
    input  y, y_q
  );

  modport slave (
    input  a, b, c, d, sel,
    output y, y_q
  );

endinterface

// File: rtl/mux4to1_dec.sv
// 2-to-4 one-hot decoder of the select code. Any code that is not one of
// the four known values (X/Z in simulation) yields no active line, so the
// AND-OR datapath downstream collapses to all-zeros.
module mux4to1_dec
  import mux4to1_pkg::*;
(
  input  sel_t    sel,
  output onehot_t onehot
);

  // Decode the select code into exactly one active line.
  always_comb begin
    onehot = 4'b0000;
    case (sel)
      SEL_A:   onehot = 4'b0001;
      SEL_B:   onehot = 4'b0010;
      SEL_C:   onehot = 4'b0100;
      SEL_D:   onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mux4to1.sv
// 4:1 selector leaf cell. y is a zero-latency AND-OR of the one-hot select
// lines with the data inputs, independent of clk and rst_n. y_q is a
// registered copy of y for pipelined consumers, cleared asynchronously.
module mux4to1
  import mux4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  mux4to1_if.slave   bus
);

  onehot_t          onehot_s;
  logic [WIDTH-1:0] y_s;
  logic [WIDTH-1:0] y_q_r;

  mux4to1_dec u_dec (
    .sel    (bus.sel),
    .onehot (onehot_s)
  );

  // Bitwise AND-OR select: each bit of y comes from the same bit of the
  // selected input; no select line active gives all-zeros.
  always_comb begin
    y_s = ({WIDTH{onehot_s[0]}} & bus.a)
        | ({WIDTH{onehot_s[1]}} & bus.b)
        | ({WIDTH{onehot_s[2]}} & bus.c)
        | ({WIDTH{onehot_s[3]}} & bus.d);
  end

  assign bus.y = y_s;

  // Registered copy of y with one cycle of latency; cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r <= {WIDTH{1'b0}};
    end else begin
      y_q_r <= y_s;
    end
  end

  assign bus.y_q = y_q_r;

endmodule

// File: tb/tb_mux4to1.sv
// Bench for mux4to1: table-driven combinational vectors at WIDTH=1 and
// WIDTH=8, plus hand-written register/reset sequences. Expected values go
// into a scoreboard queue when stimulus is applied and are popped when the
// outputs are sampled.
`timescale 1ns/1ps
module tb_mux4to1;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  logic clk;
  logic rst_n;
  logic clk_en;
  int   checks;
  int   errors;
  sb_t  sb_q[$];
  vec_t tbl1[66];
  vec_t tbl8[4];

  mux4to1_if #(.WIDTH(1)) if1 ();
  mux4to1_if #(.WIDTH(8)) if8 ();

  mux4to1 #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  mux4to1 #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  // Gated clock: idle during the combinational sweeps, 10 ns period otherwise.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] ref_sel(input logic [1:0] s, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c,
                                         input logic [7:0] d);
    case (s)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return d;
    endcase
  endfunction

  task automatic push(input string name, input logic [7:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [7:0] act);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst_n  = 1'b0;
    if1.sel = 2'b00; if1.a = 1'b0; if1.b = 1'b0; if1.c = 1'b0; if1.d = 1'b0;
    if8.sel = 2'b00; if8.a = 8'h00; if8.b = 8'h00; if8.c = 8'h00; if8.d = 8'h00;

    // Exhaustive WIDTH=1 table, {sel,a,b,c,d} = i[5:0], plus two spot checks.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = i[5:0];
      tbl1[i].sel = v[5:4];
      tbl1[i].a   = {7'b0, v[3]};
      tbl1[i].b   = {7'b0, v[2]};
      tbl1[i].c   = {7'b0, v[1]};
      tbl1[i].d   = {7'b0, v[0]};
      tbl1[i].exp = ref_sel(tbl1[i].sel, tbl1[i].a, tbl1[i].b, tbl1[i].c, tbl1[i].d);
    end
    tbl1[64] = '{sel: 2'b10, a: 8'h01, b: 8'h01, c: 8'h00, d: 8'h01, exp: 8'h00};
    tbl1[65] = '{sel: 2'b11, a: 8'h00, b: 8'h00, c: 8'h00, d: 8'h01, exp: 8'h01};

    tbl8[0] = '{sel: 2'b00, a: 8'hA5, b: 8'h3C, c: 8'hFF, d: 8'h00, exp: 8'hA5};
    tbl8[1] = '{sel: 2'b01, a: 8'hA5, b: 8'h3C, c: 8'hFF, d: 8'h00, exp: 8'h3C};
    tbl8[2] = '{sel: 2'b10, a: 8'hA5, b: 8'h3C, c: 8'hFF, d: 8'h00, exp: 8'hFF};
    tbl8[3] = '{sel: 2'b11, a: 8'hA5, b: 8'h3C, c: 8'hFF, d: 8'h00, exp: 8'h00};

    // Combinational sweeps run with reset held and no clock: y must still track.
    for (int i = 0; i < 66; i++) begin
      if1.sel = tbl1[i].sel;
      if1.a = tbl1[i].a[0]; if1.b = tbl1[i].b[0];
      if1.c = tbl1[i].c[0]; if1.d = tbl1[i].d[0];
      push($sformatf("w1_vec%0d", i), tbl1[i].exp);
      #10;
      check({7'b0, if1.y});
    end
    for (int i = 0; i < 4; i++) begin
      if8.sel = tbl8[i].sel;
      if8.a = tbl8[i].a; if8.b = tbl8[i].b;
      if8.c = tbl8[i].c; if8.d = tbl8[i].d;
      push($sformatf("w8_vec%0d", i), tbl8[i].exp);
      #10;
      check(if8.y);
    end

    // y_q held at zero by reset with no clock edge ever seen.
    push("w1_yq_reset", 8'h00);
    check({7'b0, if1.y_q});
    push("w8_yq_reset", 8'h00);
    check(if8.y_q);

    // Release reset between edges, then load b=1 on the first edge.
    if1.sel = 2'b01; if1.a = 1'b0; if1.b = 1'b1;
    if8.sel = 2'b00;
    #2;
    rst_n = 1'b1;
    #1;
    clk_en = 1'b1;
    @(posedge clk); #1;
    push("w1_yq_load_b", 8'h01);
    check({7'b0, if1.y_q});
    push("w8_yq_load_a", 8'hA5);
    check(if8.y_q);

    // y follows the new select at once; y_q waits for the next edge.
    if1.sel = 2'b00; if1.a = 1'b0;
    #1;
    push("w1_y_immediate", 8'h00);
    check({7'b0, if1.y});
    push("w1_yq_hold", 8'h01);
    check({7'b0, if1.y_q});
    @(posedge clk); #1;
    push("w1_yq_next_edge", 8'h00);
    check({7'b0, if1.y_q});

    // Get y_q back to 1, then assert reset between edges.
    if1.sel = 2'b01; if1.b = 1'b1;
    @(posedge clk); #1;
    push("w1_yq_reload", 8'h01);
    check({7'b0, if1.y_q});
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    push("w1_yq_async_clear", 8'h00);
    check({7'b0, if1.y_q});
    push("w8_yq_async_clear", 8'h00);
    check(if8.y_q);
    push("w1_y_during_reset", 8'h01);
    check({7'b0, if1.y});

    // Clock edges while in reset leave y_q at zero; y still tracks.
    @(posedge clk); #1;
    push("w1_yq_reset_hold", 8'h00);
    check({7'b0, if1.y_q});
    if1.sel = 2'b00; if1.a = 1'b1;
    #1;
    push("w1_y_track_in_reset", 8'h01);
    check({7'b0, if1.y});

    // Release reset away from an edge; the next edge loads again.
    rst_n = 1'b1;
    @(posedge clk); #1;
    push("w1_yq_after_release", 8'h01);
    check({7'b0, if1.y_q});

    clk_en = 1'b0;
    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
